// File: rtl/spi_mnrch_p.sv
// SPI master: one frame per accepted request, all four SPI modes, NUM_SS one-hot-low selects.
// SCLK edges are timed by a half-period counter; a separate counter tracks completed SCLK edges.
module spi_mnrch_p #(
  parameter int DATA_W   = 16,
  parameter int HALF_PER = 16,
  parameter int NUM_SS   = 1,
  localparam int SEL_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              snd,
  input  logic [DATA_W-1:0] cmd,
  input  logic [SEL_W-1:0]  ss_sel,
  input  logic [1:0]        mode,
  output logic              done,
  output logic              busy,
  output logic [DATA_W-1:0] resp,
  output logic [NUM_SS-1:0] SS_n,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int HW = $clog2(HALF_PER + 1);
  localparam int EW = $clog2(2 * DATA_W + 1);

  typedef enum logic [1:0] {IDLE, FRONT, XFER, BACK} state_t;

  state_t            state_reg, state_next;
  logic [HW-1:0]     hcnt_reg;
  logic [EW-1:0]     ecnt_reg;
  logic [DATA_W-1:0] tx_reg;
  logic [DATA_W-1:0] rx_reg;
  logic [SEL_W-1:0]  sel_reg;
  logic [NUM_SS-1:0] ss_n_reg;
  logic [NUM_SS-1:0] sel_onehot;
  logic              cpol_reg, cpha_reg, sclk_reg, mosi_reg, done_reg, busy_reg;
  logic              sel_ok, accept, hp_done, sclk_evt, leading, last_edge;
  logic              sample_now, shift_now;

  // When every select code maps to a real slave there is nothing to reject.
  generate
    if (NUM_SS == (1 << SEL_W)) begin : g_sel_full
      assign sel_ok = 1'b1;
    end else begin : g_sel_part
      assign sel_ok = (int'(ss_sel) < NUM_SS);
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SS; gi++) begin : g_onehot
      assign sel_onehot[gi] = (sel_reg == SEL_W'(gi));
    end
  endgenerate

  assign accept     = (state_reg == IDLE) && snd && sel_ok;
  assign hp_done    = (hcnt_reg == HW'(HALF_PER));
  assign sclk_evt   = hp_done && ((state_reg == FRONT) || (state_reg == XFER));
  // ecnt_reg counts edges already issued, so an even count means the next edge is leading.
  assign leading    = ~ecnt_reg[0];
  assign last_edge  = (ecnt_reg == EW'(2 * DATA_W - 1));
  assign sample_now = sclk_evt && (leading ^ cpha_reg);
  assign shift_now  = sclk_evt && !(leading ^ cpha_reg);

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = FRONT;
      FRONT:   if (hp_done) state_next = XFER;
      XFER:    if (hp_done && last_edge) state_next = BACK;
      BACK:    if (hp_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt_reg <= '0;
      ecnt_reg <= '0;
      tx_reg   <= '0;
      rx_reg   <= '0;
      sel_reg  <= '0;
      ss_n_reg <= '1;
      cpol_reg <= 1'b1;
      cpha_reg <= 1'b0;
      sclk_reg <= 1'b1;
      mosi_reg <= 1'b0;
      done_reg <= 1'b0;
      busy_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            tx_reg   <= cmd;
            sel_reg  <= ss_sel;
            cpol_reg <= mode[1];
            cpha_reg <= mode[0];
            sclk_reg <= mode[1];
            done_reg <= 1'b0;
            busy_reg <= 1'b1;
            hcnt_reg <= '0;
            ecnt_reg <= '0;
          end
        end
        FRONT, XFER: begin
          hcnt_reg <= hp_done ? HW'(1) : hcnt_reg + 1'b1;
          // First cycle after acceptance: assert select and, for CPHA=0, present the MSB.
          if ((state_reg == FRONT) && (hcnt_reg == '0)) begin
            ss_n_reg <= ~sel_onehot;
            if (!cpha_reg) begin
              mosi_reg <= tx_reg[DATA_W-1];
              tx_reg   <= {tx_reg[DATA_W-2:0], 1'b0};
            end
          end
          if (sclk_evt) begin
            sclk_reg <= ~sclk_reg;
            ecnt_reg <= ecnt_reg + 1'b1;
          end
          if (sample_now) rx_reg <= {rx_reg[DATA_W-2:0], MISO};
          if (shift_now) begin
            mosi_reg <= tx_reg[DATA_W-1];
            tx_reg   <= {tx_reg[DATA_W-2:0], 1'b0};
          end
        end
        BACK: begin
          if (hp_done) begin
            ss_n_reg <= '1;
            done_reg <= 1'b1;
            busy_reg <= 1'b0;
            hcnt_reg <= '0;
          end else begin
            hcnt_reg <= hcnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign done = done_reg;
  assign busy = busy_reg;
  assign resp = rx_reg;
  assign SS_n = ss_n_reg;
  assign SCLK = sclk_reg;
  assign MOSI = mosi_reg;

endmodule

// File: tb/tb_spi_mnrch_p.sv
// Bench for spi_mnrch_p: a default instance and an 8-bit/4-clk/4-slave instance,
// both checked every cycle against timing and data computed from the frame formulas.
module tb_spi_mnrch_p;

  logic        clk = 1'b0;
  logic        rst_n, snd, sel_b, loopback, miso_drv;
  logic [15:0] cmd;
  logic [1:0]  mode, ss_sel;
  int          nvec = 0;
  int          nerr = 0;

  logic        done_a, busy_a, ss_a, sclk_a, mosi_a, miso_a, snd_a;
  logic [15:0] resp_a;
  logic        done_b, busy_b, sclk_b, mosi_b, miso_b, snd_b;
  logic [7:0]  resp_b;
  logic [3:0]  ss_b;

  logic [3:0]  obs_ss;
  logic [15:0] obs_resp;
  logic        obs_sclk, obs_mosi, obs_busy, obs_done;

  assign snd_a    = snd & ~sel_b;
  assign snd_b    = snd & sel_b;
  assign miso_a   = loopback ? mosi_a : miso_drv;
  assign miso_b   = loopback ? mosi_b : miso_drv;
  assign obs_ss   = sel_b ? ss_b : {3'b111, ss_a};
  assign obs_resp = sel_b ? {8'h00, resp_b} : resp_a;
  assign obs_sclk = sel_b ? sclk_b : sclk_a;
  assign obs_mosi = sel_b ? mosi_b : mosi_a;
  assign obs_busy = sel_b ? busy_b : busy_a;
  assign obs_done = sel_b ? done_b : done_a;

  spi_mnrch_p dut_a (
    .clk(clk), .rst_n(rst_n), .snd(snd_a), .cmd(cmd), .ss_sel(ss_sel[0]), .mode(mode),
    .done(done_a), .busy(busy_a), .resp(resp_a), .SS_n(ss_a), .SCLK(sclk_a),
    .MOSI(mosi_a), .MISO(miso_a)
  );

  spi_mnrch_p #(.DATA_W(8), .HALF_PER(4), .NUM_SS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .snd(snd_b), .cmd(cmd[7:0]), .ss_sel(ss_sel), .mode(mode),
    .done(done_b), .busy(busy_b), .resp(resp_b), .SS_n(ss_b), .SCLK(sclk_b),
    .MOSI(mosi_b), .MISO(miso_b)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // SCLK edges completed by relative clk edge n: edge k happens at 1 + k*hp.
  function automatic int edges_at(input int n, input int dw, input int hp);
    int e;
    if (n < 1 + hp) return 0;
    e = (n - 1) / hp;
    return (e > 2 * dw) ? 2 * dw : e;
  endfunction

  function automatic int samples_of(input int e, input logic cpha);
    return cpha ? e / 2 : (e + 1) / 2;
  endfunction

  // One frame. pre: acceptance already happened on the previous edge (held snd).
  // hold: keep snd high so the next frame starts immediately. rst_at: abort by reset.
  task automatic run(input bit b, input logic [15:0] c, input logic [1:0] m,
                     input logic [1:0] s, input logic [15:0] r, input bit loop,
                     input bit pre, input bit hold, input int rst_at);
    int          dw, hp, endn, e, en1, sm;
    logic [15:0] mask, exp_r;
    logic [3:0]  ss_low;
    dw     = b ? 8 : 16;
    hp     = b ? 4 : 16;
    endn   = 1 + (2 * dw + 1) * hp;
    mask   = b ? 16'h00FF : 16'hFFFF;
    exp_r  = (loop ? c : r) & mask;
    ss_low = b ? ~(4'b0001 << s) : 4'b1110;
    if (!pre) begin
      @(negedge clk);
      sel_b = b; loopback = loop;
      cmd = c; mode = m; ss_sel = s; snd = 1'b1;
      @(negedge clk);
      chk("accept_busy", 64'(obs_busy), 64'(1'b1));
      chk("accept_done", 64'(obs_done), 64'(1'b0));
    end
    miso_drv = r[dw-1];
    snd = hold;
    for (int n = 1; n <= endn; n++) begin
      @(negedge clk);
      if (n == rst_at) begin
        chk("rst_ss", 64'(obs_ss), 64'(4'hF));
        chk("rst_sclk", 64'(obs_sclk), 64'(1'b1));
        chk("rst_busy", 64'(obs_busy), 64'(1'b0));
        chk("rst_done", 64'(obs_done), 64'(1'b0));
        rst_n = 1'b1;
        snd = 1'b0;
        return;
      end
      e = edges_at(n, dw, hp);
      chk("ss_n", 64'(obs_ss), 64'((n < endn) ? ss_low : 4'hF));
      chk("sclk", 64'(obs_sclk), 64'(m[1] ^ e[0]));
      chk("busy", 64'(obs_busy), 64'(n < endn));
      chk("done", 64'(obs_done), 64'(n >= endn));
      sm  = samples_of(e, m[0]);
      en1 = edges_at(n + 1, dw, hp);
      if ((n + 1 < endn) && (en1 != e) && ((en1 % 2) != int'(m[0])) && (n + 1 != rst_at))
        chk("mosi_bit", 64'(obs_mosi), 64'(c[dw-1-sm]));
      miso_drv = (sm < dw) ? r[dw-1-sm] : 1'b0;
      if (!hold) begin
        snd = (n == 9) || (n == 299);
        if (n < endn - 1) begin
          cmd = 16'($urandom); mode = 2'($urandom); ss_sel = 2'($urandom);
        end
      end
      if (n + 1 == rst_at) rst_n = 1'b0;
    end
    chk("resp", 64'(obs_resp), 64'(exp_r));
    if (hold) begin
      @(negedge clk);
      chk("b2b_done", 64'(obs_done), 64'(1'b0));
      chk("b2b_busy", 64'(obs_busy), 64'(1'b1));
      chk("b2b_ss_gap", 64'(obs_ss), 64'(4'hF));
    end
  endtask

  initial begin
    logic [15:0] c;
    logic [1:0]  m;
    rst_n = 1'b0; snd = 1'b0; sel_b = 1'b0; loopback = 1'b0; miso_drv = 1'b0;
    cmd = '0; mode = '0; ss_sel = '0;
    repeat (3) @(negedge clk);
    chk("reset_ss_a", 64'(ss_a), 64'(1'b1));
    chk("reset_ss_b", 64'(ss_b), 64'(4'hF));
    chk("reset_sclk_a", 64'(sclk_a), 64'(1'b1));
    chk("reset_sclk_b", 64'(sclk_b), 64'(1'b1));
    chk("reset_busy", 64'({busy_a, busy_b}), 64'(2'b00));
    chk("reset_done", 64'({done_a, done_b}), 64'(2'b00));
    rst_n = 1'b1;

    // Default instance, mode 0, loopback; mid-frame snd pulses at edges 10 and 300.
    run(0, 16'hA5C3, 2'd0, 2'd0, 16'h0000, 1, 0, 0, 0);
    // Mode 3 with a fixed slave word.
    run(0, 16'($urandom), 2'd3, 2'd0, 16'h3C5A, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      run(0, 16'($urandom), 2'($urandom), 2'd0, 16'($urandom), 0, 0, 0, 0);

    // Small instance: slave 2, cmd 8'h81, loopback; then random frames.
    run(1, 16'h0081, 2'd0, 2'd2, 16'h0000, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      run(1, 16'($urandom), 2'($urandom), 2'($urandom), 16'($urandom), 0, 0, 0, 0);

    // Reset at relative edge 200 aborts the frame; the next one completes.
    run(0, 16'($urandom), 2'($urandom), 2'd0, 16'($urandom), 0, 0, 0, 200);
    run(0, 16'($urandom), 2'($urandom), 2'd0, 16'($urandom), 0, 0, 0, 0);

    // snd held high: three consecutive frames.
    c = 16'($urandom);
    m = 2'($urandom);
    run(0, c, m, 2'd0, 16'($urandom), 0, 0, 1, 0);
    run(0, c, m, 2'd0, 16'($urandom), 0, 1, 1, 0);
    run(0, c, m, 2'd0, 16'($urandom), 0, 1, 0, 0);

    // Out-of-range select on the single-slave instance must not start a frame.
    @(negedge clk);
    sel_b = 1'b0; ss_sel = 2'd1; snd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("badsel_busy", 64'(busy_a), 64'(1'b0));
      chk("badsel_ss", 64'(ss_a), 64'(1'b1));
    end
    snd = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/spi_mnrch_p.md
SPI_MNRCH_P -- requirements
Module: spi_mnrch_p

Interface
REQ-001 Parameter DATA_W, default 16, frame length in bits (legal range 2..64).
REQ-002 Parameter HALF_PER, default 16, clk cycles per SCLK half-period (legal range 2..256).
REQ-003 Parameter NUM_SS, default 1, number of slave-select lines (legal range 1..8).
REQ-004 Derived SEL_W = max(1, clog2(NUM_SS)).
REQ-005 clk  in  1  system clock; all logic updates on rising edge.
REQ-006 rst_n  in  1  reset; synchronous and active-low.
REQ-007 snd  in  1  start request; sampled only in IDLE.
REQ-008 cmd  in  DATA_W  transmit word, MSB first.
REQ-009 ss_sel  in  SEL_W  target slave index; values >= NUM_SS are ignored (snd not accepted).
REQ-010 mode  in  2  {CPOL, CPHA}, SPI mode 0..3.
REQ-011 done  out  1  level; high after frame completes, until next accepted snd.
REQ-012 busy  out  1  high from acceptance until done rises.
REQ-013 resp  out  DATA_W  received word, valid while done=1.
REQ-014 SS_n  out  NUM_SS  active-low selects, one-hot-low during a frame.
REQ-015 SCLK  out  1  serial clock.
REQ-016 MOSI  out  1  serial data out.
REQ-017 MISO  in  1  serial data in.

Function
REQ-018 FSM states IDLE, FRONT, XFER, BACK; IDLE->FRONT on accepted snd; FRONT->XFER after HALF_PER clks; XFER->BACK after 2*DATA_W SCLK edges; BACK->IDLE after HALF_PER clks.
REQ-019 Accepted snd (edge 0) latches cmd, mode, ss_sel, clears done, sets busy; selected SS_n bit low from edge 1.
REQ-020 SCLK idles at latched CPOL; SCLK edge k (k=1..2*DATA_W) occurs at edge 1+k*HALF_PER; odd k = leading edge (CPOL->!CPOL), even k = trailing.
REQ-021 CPHA=0: MOSI = cmd MSB from edge 1; MISO sampled on leading edges; MOSI advances on trailing edges.
REQ-022 CPHA=1: MOSI advances on leading edges (first at edge 1+HALF_PER); MISO sampled on trailing edges.
REQ-023 MISO bits shift in MSB first; after the last sample resp holds exactly DATA_W received bits.
REQ-024 At edge 1+(2*DATA_W+1)*HALF_PER: SS_n all high, done=1, busy=0, state IDLE.
REQ-025 snd during FRONT/XFER/BACK ignored; cmd/mode/ss_sel changes mid-frame have no effect.
REQ-026 snd high in the same cycle done rises is not accepted; earliest acceptance is the following cycle.
REQ-027 Back-to-back: snd held high re-accepts on first IDLE cycle; SS_n deasserted at least 1 cycle between frames.
REQ-028 SCLK level in IDLE after a frame = last latched CPOL; MOSI in IDLE = last shift-register MSB (don't-care).
REQ-029 resp retains value until the next frame's first sample.

Reset
REQ-030 rst_n=0 at a clk edge, any state: state IDLE, SS_n all 1, SCLK 1, done 0, busy 0, latched CPOL 1, counters 0.
REQ-031 Reset mid-frame aborts with no done pulse; resp value after reset is don't-care until next frame.

Verification
REQ-032 Defaults, mode 0, cmd 16'hA5C3, MISO loopback from MOSI -> resp 16'hA5C3, done at edge 529, SS_n[0] low edges 1..528.
REQ-033 Mode 3 (CPOL=1,CPHA=1), slave returns 16'h3C5A -> resp 16'h3C5A, SCLK idle high, 16 rising sampling edges.
REQ-034 DATA_W=8, HALF_PER=4, NUM_SS=4, ss_sel=2, cmd 8'h81 -> only SS_n[2] low, done at edge 69, MOSI bit sequence 1000_0001.
REQ-035 snd pulsed at edges 10 and 300 during frame -> ignored, exactly one frame, one done rise.
REQ-036 rst_n low at edge 200 mid-frame -> edge 200: SS_n all 1, SCLK 1, busy 0, done 0; new snd afterward completes normally.
REQ-037 snd held high continuously -> consecutive frames, SS_n high >=1 cycle between, done toggles 1 then 0 each frame.
